dmem_sync_be: RTL
=================

DMEM_SYNC_BE -- requirements
Module: dmem_sync_be

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, word-address width; depth = 2**ADDR_W words.
REQ-002 SHALL have parameter DATA_W, default 32, word width; legal values are multiples of 8 only.
REQ-003 SHALL have parameter CLEAR_ON_RESET, default 1; when 1, the array is zero-filled after reset.
REQ-004 SHALL have port clk_i, input, 1 bit, single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port rst_ni, input, 1 bit; reset is asynchronous and active-low.
REQ-006 SHALL have port req_i, input, 1 bit, access request.
REQ-007 SHALL have port we_i, input, 1 bit; 1 means write, 0 means read.
REQ-008 SHALL have port addr_i, input, ADDR_W bits, word address.
REQ-009 SHALL have port wdata_i, input, DATA_W bits, write data.
REQ-010 SHALL have port be_i, input, DATA_W/8 bits, byte enables, where bit k covers byte lane k.
REQ-011 SHALL have port ready_o, output, 1 bit, asserted when the block can accept a request.
REQ-012 SHALL have port rvalid_o, output, 1 bit, read data valid.
REQ-013 SHALL have port rdata_o, output, DATA_W bits, read data.

Function
REQ-014 A request SHALL be accepted only on a cycle with req_i=1 and ready_o=1; req_i while ready_o=0 SHALL be ignored with no side effects.
REQ-015 An accepted write SHALL update only the byte lanes whose be_i bit is 1, at that clock edge; be_i=0 SHALL leave memory unchanged.
REQ-016 An accepted write SHALL NOT assert rvalid_o.
REQ-017 An accepted read SHALL have 1-cycle latency: rvalid_o=1 and rdata_o=mem[addr_i] on the next cycle; be_i SHALL be ignored for reads.
REQ-018 rvalid_o SHALL be a one-cycle pulse per accepted read; back-to-back reads SHALL produce back-to-back rvalid_o pulses.
REQ-019 rdata_o SHALL hold its last value while rvalid_o=0.
REQ-020 A read accepted the cycle after a write to the same address SHALL return the newly written data, with no bypass path needed.
REQ-021 The FSM SHALL have exactly two states. CLEAR: ready_o=0; an ADDR_W-bit counter writes zero to mem[cnt] each cycle. IDLE: ready_o=1.
REQ-022 Leaving reset SHALL enter CLEAR when CLEAR_ON_RESET=1, and IDLE otherwise; with CLEAR_ON_RESET=0, memory contents after reset are undefined.
REQ-023 In CLEAR, when the counter reaches 2**ADDR_W-1, that word SHALL be written and the FSM SHALL move to IDLE on the next edge; CLEAR therefore lasts exactly 2**ADDR_W cycles.
REQ-024 Reset asserted during CLEAR or during a pending read SHALL abort the operation; the clear restarts from address 0 and the pending rvalid_o is dropped.

Reset
REQ-025 While rst_ni=0 (asynchronous): rvalid_o=0, rdata_o=0, clear counter=0, FSM state=CLEAR (or IDLE if CLEAR_ON_RESET=0), and ready_o=0.
REQ-026 The memory array SHALL have no reset; its contents are preserved across reset when CLEAR_ON_RESET=0.
REQ-027 ready_o SHALL first rise no earlier than the first clock edge after rst_ni deasserts.

Structure
REQ-028 Package dmem_pkg SHALL hold the FSM state enum (DM_CLEAR, DM_IDLE) and the default ADDR_W/DATA_W constants.
REQ-029 The byte-lane write-merge function SHALL reside in dmem_pkg.
REQ-030 The clear sequencer SHALL be a sub-module, dmem_clr_seq, containing the counter, the FSM, and a done output; the array and read register SHALL stay in dmem_sync_be.

Verification
REQ-031 Clear after reset: CLEAR_ON_RESET=1, ADDR_W=4, release reset -> ready_o=0 for 16 cycles, then 1; reads of all 16 addresses return 0.
REQ-032 Byte enables: write 0xDEADBEEF with be=1111 to addr 0x05, then 0x00001200 with be=0010, then read 0x05 -> rdata_o=0xDEAD12EF with rvalid_o one cycle after acceptance.
REQ-033 Back-to-back access: write 0xA5A5A5A5 to addr 0x10, then read 0x10 on the next cycle, then read 0x11 on the following cycle -> two consecutive rvalid_o pulses, returning 0xA5A5A5A5 then 0x00000000.
REQ-034 Blocked request: req_i=1 with we_i=1 to addr 0x03 during CLEAR -> ignored; after clear completes, a read of addr 0x03 returns 0.
REQ-035 Reset mid-clear: assert rst_ni=0 at clear cycle 7 for 2 cycles -> rvalid_o=0, rdata_o=0, and the clear restarts at address 0, taking the full 2**ADDR_W cycles.
REQ-036 Reset mid-read: accept a read, then assert rst_ni=0 before the next edge -> no rvalid_o pulse, rdata_o=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared state type, default widths and byte-lane merge helper for dmem_sync_be
package dmem_pkg;

  localparam int DMEM_ADDR_W = 8;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic {
    DM_CLEAR = 1'b0,
    DM_IDLE  = 1'b1
  } dm_state_e;

  // One byte lane of a partial write: keep the stored byte unless its enable is set.
  function automatic logic [7:0] be_merge_byte(input logic [7:0] old_b,
                                               input logic [7:0] new_b,
                                               input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/dmem_clr_seq.sv
// rtl/dmem_clr_seq.sv - post-reset zero-fill sequencer: address counter, two-state FSM, done flag
module dmem_clr_seq
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = DMEM_ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o,
  output logic              done_o
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  dm_state_e         state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              done_q;

  // done_q is registered so ready cannot rise before the first edge after reset release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLEAR_ON_RESET ? DM_CLEAR : DM_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else if (state_q == DM_CLEAR) begin
      cnt_q <= cnt_q + ADDR_W'(1);
      if (cnt_q == LAST_ADDR) begin
        state_q <= DM_IDLE;
        done_q  <= 1'b1;
      end
    end else begin
      done_q <= 1'b1;
    end
  end

  assign clr_we_o   = (state_q == DM_CLEAR);
  assign clr_addr_o = cnt_q;
  assign done_o     = done_q;

endmodule

// File: rtl/dmem_sync_be.sv
// rtl/dmem_sync_be.sv - single-port synchronous data memory with byte enables and zero-fill after reset
module dmem_sync_be
  import dmem_pkg::*;
#(
  parameter int ADDR_W         = DMEM_ADDR_W,
  parameter int DATA_W         = DMEM_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_i,
  input  logic                we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] be_i,
  output logic                ready_o,
  output logic                rvalid_o,
  output logic [DATA_W-1:0]   rdata_o
);

  localparam int NUM_BYTES = DATA_W / 8;
  localparam int DEPTH     = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;
  logic              clr_done;
  logic              acc_wr;
  logic              acc_rd;
  logic [DATA_W-1:0] merged;

  dmem_clr_seq #(
    .ADDR_W         (ADDR_W),
    .CLEAR_ON_RESET (CLEAR_ON_RESET)
  ) u_clr_seq (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr),
    .done_o     (clr_done)
  );

  assign ready_o = clr_done;
  assign acc_wr  = req_i & ready_o & we_i;
  assign acc_rd  = req_i & ready_o & ~we_i;

  always_comb begin
    merged = '0;
    for (int k = 0; k < NUM_BYTES; k++) begin
      merged[8*k +: 8] = be_merge_byte(mem_q[addr_i][8*k +: 8], wdata_i[8*k +: 8], be_i[k]);
    end
  end

  // The array has no reset; the clear sequencer and user writes never overlap since ready_o is low during clear.
  always_ff @(posedge clk_i) begin
    if (clr_we) begin
      mem_q[clr_addr] <= '0;
    end else if (acc_wr) begin
      mem_q[addr_i] <= merged;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_o <= 1'b0;
      rdata_o  <= '0;
    end else begin
      rvalid_o <= acc_rd;
      if (acc_rd) begin
        rdata_o <= mem_q[addr_i];
      end
    end
  end

endmodule
